// File: rtl/bnn_layer_seq.sv
// Time-multiplexed binary neural-network layer.
// Holds one IN_W-bit weight and one CNT_W-bit threshold per neuron. These are
// loaded over a narrow beat stream. Neurons are evaluated one per cycle with
// XNOR-popcount-threshold, and the activation vector is returned over a
// valid/ready output.
//
// Handshake rule, used by every port pair here: a transfer happens on a rising
// edge where valid && ready are both high. ready never depends on valid. A
// producer keeps its payload stable while valid is high and not yet accepted.
module bnn_layer_seq #(
    parameter int IN_W        = 8,
    parameter int NUM_NEURONS = 8,
    parameter int LOAD_W      = 4,
    parameter int CNT_W       = $clog2(IN_W + 1),
    parameter int BEATS       = (IN_W + CNT_W + LOAD_W - 1) / LOAD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    input  logic [LOAD_W-1:0]      load_data,
    output logic                   load_ready,
    output logic                   load_done,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [NUM_NEURONS-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int REC_W = BEATS * LOAD_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state;
    logic [IN_W-1:0]    weight_mem [NUM_NEURONS];
    logic [CNT_W-1:0]   thr_mem    [NUM_NEURONS];
    logic [BC_W-1:0]    beat_cnt;
    logic [PTR_W-1:0]   ld_ptr;
    logic [REC_W-1:0]   rec_buf;
    logic [REC_W-1:0]   full_rec;
    logic [IN_W-1:0]    x_reg;
    logic [PTR_W-1:0]   idx;
    logic [IN_W-1:0]    xn;
    logic [CNT_W-1:0]   pc;
    logic               fire;
    logic               load_fire;
    logic               in_fire;
    logic               last_beat;
    logic               last_neuron;
    logic               load_in_progress;

    // Ready/status flags decode only the state register and load counters.
    always_comb begin
        load_in_progress = (beat_cnt != '0) || (ld_ptr != '0);
        load_ready       = (state == S_IDLE);
        in_ready         = (state == S_IDLE) && !load_in_progress;
        out_valid        = (state == S_OUT);
        busy             = (state == S_EVAL) || (state == S_OUT);
        state_dbg        = state;
        load_fire        = load_valid && load_ready;
        in_fire          = in_valid && in_ready;
        last_beat        = (beat_cnt == BC_W'(BEATS - 1));
        last_neuron      = (ld_ptr == PTR_W'(NUM_NEURONS - 1));
    end

    // Merge the incoming beat into the partially collected record.
    always_comb begin
        full_rec = rec_buf;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == BC_W'(b)) begin
                full_rec[b*LOAD_W +: LOAD_W] = load_data;
            end
        end
    end

    // Collect load beats. On the final beat of a record, write the neuron
    // storage and advance the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt  <= '0;
            ld_ptr    <= '0;
            rec_buf   <= '0;
            load_done <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                weight_mem[n] <= '0;
                thr_mem[n]    <= '0;
            end
        end else begin
            load_done <= load_fire && last_beat && last_neuron;
            if (load_fire) begin
                if (last_beat) begin
                    beat_cnt           <= '0;
                    rec_buf            <= '0;
                    weight_mem[ld_ptr] <= full_rec[IN_W-1:0];
                    thr_mem[ld_ptr]    <= full_rec[IN_W +: CNT_W];
                    ld_ptr             <= last_neuron ? '0 : ld_ptr + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    rec_buf  <= full_rec;
                end
            end
        end
    end

    // XNOR-popcount of the latched input against the current neuron's weight.
    // The popcount is compared unsigned at CNT_W bits. A threshold of 0
    // therefore always fires, and one above IN_W never fires.
    always_comb begin
        xn = ~(x_reg ^ weight_mem[idx]);
        pc = '0;
        for (int i = 0; i < IN_W; i++) begin
            pc = pc + CNT_W'(xn[i]);
        end
        fire = (pc >= thr_mem[idx]);
    end

    // Control FSM: accept an input, sweep the neurons, hold the result until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            x_reg    <= '0;
            idx      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        x_reg <= in_data;
                        idx   <= '0;
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    out_data[idx] <= fire;
                    if (idx == PTR_W'(NUM_NEURONS - 1)) begin
                        idx   <= '0;
                        state <= S_OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed testbench for bnn_layer_seq at default sizing (8 inputs, 8 neurons, 3 beats/neuron).
module tb_bnn_layer_seq;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic       load_done;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic [1:0] state_dbg;

    int checks;
    int failures;

    logic [7:0] ld_w [8];
    logic [3:0] ld_t [8];

    bnn_layer_seq dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Send beats first..last of the full 24-beat load image held in ld_w/ld_t.
    task automatic send_beats(input int first, input int last, input bit chk_in_low,
                              output int done_cnt, output int done_at);
        logic [11:0] rec;
        int          k;
        int          n;
        int          wait_cnt;
        done_cnt = 0;
        done_at  = -1;
        for (int b = first; b <= last; b++) begin
            n = b / 3;
            k = b % 3;
            rec        = {ld_t[n], ld_w[n]};
            load_data  = rec[k*4 +: 4];
            load_valid = 1'b1;
            if (chk_in_low) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_during_load beat %0d: got %b want 0", b, in_ready);
                end
            end
            wait_cnt = 0;
            while (load_ready !== 1'b1 && wait_cnt < 40) begin
                tick();
                wait_cnt++;
            end
            if (wait_cnt >= 40) begin
                checks++;
                failures++;
                $display("FAIL load_ready_timeout beat %0d: got 0 want 1", b);
            end
            tick();
            if (load_done === 1'b1) begin
                done_cnt++;
                done_at = b;
            end
        end
        load_valid = 1'b0;
    endtask

    // One inference: check latency, busy profile, result, and the return to idle.
    task automatic run_input(input logic [7:0] x, input logic [7:0] exp, input string name);
        int lat;
        int wait_cnt;
        bit busy_bad;
        wait_cnt = 0;
        while (in_ready !== 1'b1 && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        busy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            lat++;
        end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL %s_latency: got %0d want 8", name, lat);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL %s_busy_eval: got 0 want 1 during EVAL", name);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_out: got %b want 1", name, busy);
        end
        checks++;
        if (out_data !== exp) begin
            failures++;
            $display("FAIL %s_data: got %h want %h", name, out_data, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: got valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_after: got %b want 1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || load_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h ld=%b b=%b want 0 00 0 0",
                     out_valid, out_data, load_done, busy);
        end
        checks++;
        if (load_ready !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got lr=%b ir=%b want 1 1", load_ready, in_ready);
        end
        run_input(8'hA5, 8'hFF, "reset_default");
    endtask

    task automatic test_full_load();
        int dc;
        int da;
        for (int n = 0; n < 8; n++) begin
            ld_w[n] = (n < 4) ? 8'hF0 : 8'h0F;
            ld_t[n] = 4'd5;
        end
        send_beats(0, 23, 1'b0, dc, da);
        checks++;
        if (dc != 1 || da != 23) begin
            failures++;
            $display("FAIL load_done_pulse: got count=%0d at=%0d want 1 at 23", dc, da);
        end
        tick();
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL load_done_width: got %b want 0", load_done);
        end
        run_input(8'hF0, 8'h0F, "full_f0");
        run_input(8'h0F, 8'hF0, "full_0f");
    endtask

    task automatic test_thresholds();
        int dc;
        int da;
        for (int n = 0; n < 8; n++) begin
            ld_w[n] = 8'hFF;
            ld_t[n] = 4'd4;
        end
        ld_t[0] = 4'd8;
        ld_t[1] = 4'd9;
        ld_t[2] = 4'd0;
        send_beats(0, 23, 1'b0, dc, da);
        // pc=8: n1 (thr 9) is the only one that stays quiet
        run_input(8'hFF, 8'hFD, "thr_ff");
        // pc=7: n0 (thr 8) and n1 drop out
        run_input(8'hFE, 8'hFC, "thr_fe");
    endtask

    task automatic test_backpressure();
        int wait_cnt;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_data    = 8'h00;
        load_valid = 1'b1;
        load_data  = 4'h5;
        wait_cnt   = 0;
        while (out_valid !== 1'b1 && wait_cnt < 30) begin
            tick();
            wait_cnt++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hFD || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cyc %0d: got v=%b d=%h b=%b want 1 fd 1", c, out_valid, out_data, busy);
            end
            checks++;
            if (in_ready !== 1'b0 || load_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready cyc %0d: got ir=%b lr=%b want 0 0", c, in_ready, load_ready);
            end
            tick();
        end
        in_valid   = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_after: got v=%b ir=%b want 0 1", out_valid, in_ready);
        end
        run_input(8'hFF, 8'hFD, "bp_recheck");
    endtask

    task automatic test_overlap();
        int dc;
        int da;
        int wait_cnt;
        for (int n = 0; n < 8; n++) begin
            ld_w[n] = 8'hAA;
            ld_t[n] = 4'd6;
        end
        in_valid   = 1'b1;
        in_data    = 8'h0F;
        load_valid = 1'b1;
        load_data  = ld_w[0][3:0];
        tick();
        in_valid   = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ovl_accept: got busy=%b ir=%b want 1 0", busy, in_ready);
        end
        wait_cnt = 0;
        while (out_valid !== 1'b1 && wait_cnt < 30) begin
            tick();
            wait_cnt++;
        end
        // old storage (all 0xFF, thr 8,9,0,4..) still active: pc=4
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFC) begin
            failures++;
            $display("FAIL ovl_data: got v=%b d=%h want 1 fc", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovl_partial_ready: got ir=%b lr=%b want 0 1", in_ready, load_ready);
        end
        send_beats(1, 23, 1'b1, dc, da);
        checks++;
        if (dc != 1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovl_load_end: got done=%0d ir=%b want 1 1", dc, in_ready);
        end
        run_input(8'h00, 8'h00, "ovl_00");
        run_input(8'hA0, 8'hFF, "ovl_a0");

        // partial load of 5 beats blocks new inputs
        send_beats(0, 4, 1'b0, dc, da);
        in_valid = 1'b1;
        in_data  = 8'h33;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL partial_in_ready: got %b want 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL partial_accept: got busy=%b want 0", busy);
        end
        send_beats(5, 23, 1'b1, dc, da);
        checks++;
        if (in_ready !== 1'b1 || dc != 1) begin
            failures++;
            $display("FAIL partial_finish: got ir=%b done=%0d want 1 1", in_ready, dc);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        int da;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_eval_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_eval_now: got v=%b b=%b want 0 0", out_valid, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_eval_ready: got ir=%b lr=%b want 1 1", in_ready, load_ready);
        end
        run_input(8'h00, 8'hFF, "rst_eval_clear");

        send_beats(0, 6, 1'b0, dc, da);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_load_pre: got ir=%b want 0", in_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_load_now: got v=%b b=%b want 0 0", out_valid, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_load_ready: got ir=%b want 1", in_ready);
        end
        run_input(8'h00, 8'hFF, "rst_load_clear");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_load();
        test_thresholds();
        test_backpressure();
        test_overlap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bnn_layer_seq.md
# bnn_layer_seq

Parametrised, time-multiplexed binary neural-network layer. It holds IN_W-bit weights and per-neuron thresholds for NUM_NEURONS neurons, loaded over a narrow valid/ready stream. It evaluates one neuron per cycle using XNOR-popcount-threshold and returns the NUM_NEURONS-bit activation vector through a valid/ready output. Layers are chained output-to-input to build multi-layer networks with arbitrary widths, replacing fixed, fully unrolled layers.

## Interface
- IN_W, default 8: input vector width and weight width per neuron.
- NUM_NEURONS, default 8: number of neurons, which is also the output vector width.
- LOAD_W, default 4: load stream beat width.
- CNT_W, derived, $clog2(IN_W+1): width of the popcount and of each threshold.
- BEATS, derived, ceil((IN_W+CNT_W)/LOAD_W): load beats per neuron.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load beat present.
- load_data  in  LOAD_W  load beat payload.
- load_ready  out  1  high when the block accepts a load beat.
- load_done  out  1  one-cycle pulse after the last beat of neuron NUM_NEURONS-1 is accepted.
- in_valid  in  1  input vector present.
- in_data  in  IN_W  binary input vector.
- in_ready  out  1  high when the block accepts an input vector.
- out_valid  out  1  activation vector valid.
- out_data  out  NUM_NEURONS  activation vector; bit k is neuron k.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high while in EVAL or OUT.

## Operation
- Storage per neuron: weight[IN_W] and threshold[CNT_W]. Reset clears every weight and every threshold to 0.
- Load record for neuron n: {threshold, weight}, zero-padded at the MSB end to BEATS*LOAD_W bits.
  - Beats arrive LSB chunk first.
  - Neurons are loaded in order 0..NUM_NEURONS-1.
  - Default sizing is 3 beats per neuron: weight[3:0], then weight[7:4], then threshold.
- Load bookkeeping: a beat counter and a neuron pointer.
  - On the final beat of a record, the whole record is written to neuron[ptr] and ptr increments.
  - After neuron NUM_NEURONS-1, ptr wraps to 0 and load_done pulses.
  - Padding bits are ignored.
- "Load in progress": the beat counter is non-zero or ptr is non-zero.
- FSM states:
  - IDLE: load_ready=1. in_ready=1 only if no load is in progress. An in_valid&&in_ready handshake latches in_data, sets idx=0, and moves to EVAL.
  - EVAL: load_ready=0, in_ready=0. Each cycle, pc = popcount(~(x ^ weight[idx])). Then out_data[idx] <= (pc >= threshold[idx]), unsigned compare at CNT_W bits. idx increments; after idx=NUM_NEURONS-1, move to OUT.
  - OUT: out_valid=1 and out_data is held stable. On out_ready, move to IDLE.
- Simultaneous load and input handshakes in IDLE: both are accepted. The beat is applied at that edge, and EVAL uses memory contents after that edge. Once the beat is applied a load is in progress, so in_ready stays low until the load completes.
- Threshold semantics:
  - A threshold of 0 always fires.
  - A threshold greater than IN_W never fires.
- out_data keeps its last value in IDLE. During EVAL it is overwritten bit by bit, so it is only meaningful while out_valid=1.
- Asserting reset in any state returns to IDLE:
  - Load pointer and beat counter are zeroed.
  - Weight and threshold storage is cleared.
  - Any in-flight evaluation is discarded.

## Timing
- Reset values:
  - out_valid=0, out_data=0, load_done=0, busy=0.
  - load_ready=1 and in_ready=1 once reset is released.
- Input latency:
  - Input accepted at edge T; neuron k is evaluated in the cycle following edge T+k.
  - out_valid rises after edge T+NUM_NEURONS and stays high until the out_ready handshake.
  - The next input can be accepted at the edge after the output handshake, giving a minimum period of NUM_NEURONS+2 cycles.
- Load throughput: one beat per cycle while in IDLE. A full load takes NUM_NEURONS*BEATS beats. load_done is high in the cycle after the final beat's edge.
- busy rises with the EVAL entry edge and falls with the out_ready handshake edge.
- in_ready and load_ready are functions of state and load counters only; they do not depend on in_valid or load_valid.

## Test plan
- Reset default storage: reset, then input 0xA5 -> out_valid rises 8 cycles after the accept edge with out_data=0xFF. busy is high for exactly those 8 cycles plus the OUT cycle.
- Full load and inference:
  - Load neurons 0-3 with weight 0xF0, threshold 5, and neurons 4-7 with weight 0x0F, threshold 5 (24 beats). load_done pulses once.
  - Input 0xF0 -> out_data=0x0F.
  - Input 0x0F -> out_data=0xF0.
- Threshold boundaries: every neuron gets weight 0xFF; neuron 0 threshold 8, neuron 1 threshold 9, neuron 2 threshold 0.
  - Input 0xFF -> bits 0 and 2 set, bit 1 clear.
  - Input 0xFE -> bit 0 clear, bit 2 set.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, out_data and busy are stable. in_ready=0 and load_ready=0 throughout, and in_valid/load_valid asserted during this time are not accepted.
- Handshake overlap:
  - load_valid and in_valid high together in IDLE -> both accepted, and in_ready is low from the next cycle until the 24th beat is accepted.
  - A partial load (5 beats) blocks in_ready.
- Reset mid-operation: assert reset at EVAL cycle 4, and separately after 7 load beats -> out_valid=0 and busy=0 immediately. After release, in_ready=1, and input 0x00 yields 0xFF (storage was cleared).
